sine_wave_analyzer: RTL and testbench

Receive-side measurement block for the test environment. It consumes a stream of signed sine samples, such as the quarter-wave DDS generator output or the FIR filter output, and detects rising zero crossings with hysteresis. For each window of 2^AVERAGE_LOG2 periods it reports the period in samples, the peak, the trough and the amplitude, with a one-cycle valid pulse.

---
 rtl/sine_wave_analyzer.sv | 134 +++++++++++++
 tb/tb_sine_wave_analyzer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sine_wave_analyzer.sv
// Rising zero-crossing analyzer with hysteresis arming.
// Reports period, peak, trough and amplitude once per window of periods.
module sine_wave_analyzer #(
    parameter int          SAMPLE_WIDTH    = 16,
    parameter int          PERIOD_WIDTH    = 32,
    parameter int          HYSTERESIS      = 256,
    parameter int          AVERAGE_LOG2    = 2,
    parameter int unsigned TIMEOUT_SAMPLES = 1048576
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    sample_valid,
    input  logic [SAMPLE_WIDTH-1:0] sample,
    output logic [PERIOD_WIDTH-1:0] period_sum,
    output logic [PERIOD_WIDTH-1:0] period,
    output logic [SAMPLE_WIDTH-1:0] peak,
    output logic [SAMPLE_WIDTH-1:0] trough,
    output logic [SAMPLE_WIDTH-1:0] amplitude,
    output logic                    measurement_valid,
    output logic                    locked,
    output logic                    timeout
);

    localparam int CW     = AVERAGE_LOG2 + 1;
    localparam int WINDOW = 1 << AVERAGE_LOG2;
    localparam logic signed [SAMPLE_WIDTH:0] NEG_HYST =
        (SAMPLE_WIDTH+1)'(-HYSTERESIS);

    typedef enum logic [1:0] {IDLE, SEEK, MEASURE} state_t;

    state_t                    state;
    logic                      armed;
    logic [PERIOD_WIDTH-1:0]   window_count;
    logic [CW-1:0]             crossings;
    logic signed [SAMPLE_WIDTH-1:0] peak_trk;
    logic signed [SAMPLE_WIDTH-1:0] trough_trk;

    logic signed [SAMPLE_WIDTH-1:0] s;
    logic signed [SAMPLE_WIDTH:0]   s_ext;
    logic signed [SAMPLE_WIDTH:0]   span;
    logic arm_lvl;
    logic crossing;
    logic terminal;
    logic timeout_hit;

    assign s           = $signed(sample);
    assign s_ext       = {s[SAMPLE_WIDTH-1], s};
    assign arm_lvl     = s_ext <= NEG_HYST;
    assign crossing    = armed && !s[SAMPLE_WIDTH-1];
    assign terminal    = crossing && (crossings == CW'(WINDOW - 1));
    assign timeout_hit = window_count == PERIOD_WIDTH'(TIMEOUT_SAMPLES);
    // Extra bit keeps peak - trough exact for full-scale swings.
    assign span = {peak_trk[SAMPLE_WIDTH-1], peak_trk}
                - {trough_trk[SAMPLE_WIDTH-1], trough_trk};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            armed             <= 1'b0;
            window_count      <= '0;
            crossings         <= '0;
            peak_trk          <= '0;
            trough_trk        <= '0;
            period_sum        <= '0;
            period            <= '0;
            peak              <= '0;
            trough            <= '0;
            amplitude         <= '0;
            measurement_valid <= 1'b0;
            locked            <= 1'b0;
            timeout           <= 1'b0;
        end else begin
            measurement_valid <= 1'b0;
            timeout           <= 1'b0;
            if (!enable) begin
                state        <= IDLE;
                armed        <= 1'b0;
                window_count <= '0;
                crossings    <= '0;
                locked       <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: state <= SEEK;
                    SEEK: if (sample_valid) begin
                        if (crossing) begin
                            state        <= MEASURE;
                            armed        <= 1'b0;
                            window_count <= PERIOD_WIDTH'(1);
                            crossings    <= '0;
                            peak_trk     <= s;
                            trough_trk   <= s;
                        end else if (arm_lvl) begin
                            armed <= 1'b1;
                        end
                    end
                    MEASURE: if (sample_valid) begin
                        if (terminal) begin
                            period_sum        <= window_count;
                            period            <= window_count >> AVERAGE_LOG2;
                            peak              <= peak_trk;
                            trough            <= trough_trk;
                            amplitude         <= SAMPLE_WIDTH'(span >>> 1);
                            measurement_valid <= 1'b1;
                            locked            <= 1'b1;
                            armed             <= 1'b0;
                            window_count      <= PERIOD_WIDTH'(1);
                            crossings         <= '0;
                            peak_trk          <= s;
                            trough_trk        <= s;
                        end else if (timeout_hit) begin
                            timeout <= 1'b1;
                            locked  <= 1'b0;
                            armed   <= 1'b0;
                            state   <= SEEK;
                        end else begin
                            window_count <= window_count + 1'b1;
                            if (s > peak_trk) peak_trk <= s;
                            if (s < trough_trk) trough_trk <= s;
                            if (crossing) begin
                                crossings <= crossings + 1'b1;
                                armed     <= 1'b0;
                            end else if (arm_lvl) begin
                                armed <= 1'b1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sine_wave_analyzer.sv
// Self-checking bench for sine_wave_analyzer.
// Queue-based window model plus directed literal checks.
module tb_sine_wave_analyzer;

    localparam int T    = 64;
    localparam int HYST = 256;
    localparam int NWIN = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        sample_valid = 1'b0;
    logic [15:0] sample = '0;
    logic [31:0] period_sum;
    logic [31:0] period;
    logic [15:0] peak;
    logic [15:0] trough;
    logic [15:0] amplitude;
    logic        measurement_valid;
    logic        locked;
    logic        timeout;

    sine_wave_analyzer #(
        .SAMPLE_WIDTH(16),
        .PERIOD_WIDTH(32),
        .HYSTERESIS(HYST),
        .AVERAGE_LOG2(2),
        .TIMEOUT_SAMPLES(T)
    ) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .sample_valid(sample_valid),
        .sample(sample),
        .period_sum(period_sum),
        .period(period),
        .peak(peak),
        .trough(trough),
        .amplitude(amplitude),
        .measurement_valid(measurement_valid),
        .locked(locked),
        .timeout(timeout)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // model state: the window is simply the list of its samples
    bit m_idle = 1;
    bit m_inwin = 0;
    bit m_armed = 0;
    int m_nx = 0;
    int q[$];
    int e_psum = 0, e_per = 0, e_peak = 0, e_trough = 0, e_amp = 0;
    int e_mv = 0, e_lock = 0, e_to = 0;

    int cyc = 0;
    int n_pulse = 0;
    int n_to = 0;
    int last_psum = 0;
    int last_per = 0;
    int last_pulse_cyc = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_idle = 1; m_inwin = 0; m_armed = 0; m_nx = 0;
        q.delete();
        e_psum = 0; e_per = 0; e_peak = 0; e_trough = 0; e_amp = 0;
        e_mv = 0; e_lock = 0; e_to = 0;
    endtask

    task automatic model_step(input bit en, input bit v, input int s);
        bit cr;
        int mx, mn;
        e_mv = 0;
        e_to = 0;
        if (!en) begin
            m_idle = 1; m_inwin = 0; m_armed = 0; m_nx = 0;
            q.delete();
            e_lock = 0;
            return;
        end
        if (m_idle) begin
            m_idle = 0;
            return;
        end
        if (!v) return;
        cr = m_armed && (s >= 0);
        if (!m_inwin) begin
            if (cr) begin
                m_inwin = 1; m_armed = 0; m_nx = 0;
                q.delete(); q.push_back(s);
            end else if (s <= -HYST) m_armed = 1;
            return;
        end
        if (cr && m_nx == NWIN - 1) begin
            mx = q[0]; mn = q[0];
            foreach (q[i]) begin
                if (q[i] > mx) mx = q[i];
                if (q[i] < mn) mn = q[i];
            end
            e_psum = q.size();
            e_per = q.size() / NWIN;
            e_peak = mx; e_trough = mn;
            e_amp = (mx - mn) / 2;
            e_mv = 1; e_lock = 1;
            m_armed = 0; m_nx = 0;
            q.delete(); q.push_back(s);
        end else if (q.size() == T) begin
            e_to = 1; e_lock = 0;
            m_armed = 0; m_inwin = 0;
            q.delete();
        end else begin
            q.push_back(s);
            if (cr) begin
                m_nx++;
                m_armed = 0;
            end else if (s <= -HYST) m_armed = 1;
        end
    endtask

    task automatic compare();
        chk("measurement_valid", int'(measurement_valid), e_mv);
        chk("locked", int'(locked), e_lock);
        chk("timeout", int'(timeout), e_to);
        chk("period_sum", int'(period_sum), e_psum);
        chk("period", int'(period), e_per);
        chk("peak", int'($signed(peak)), e_peak);
        chk("trough", int'($signed(trough)), e_trough);
        chk("amplitude", int'(amplitude), e_amp);
    endtask

    task automatic cycle(input bit en, input bit v, input int s);
        enable = en;
        sample_valid = v;
        sample = 16'(s);
        cyc++;
        @(posedge clock);
        model_step(en, v, s);
        #1;
        compare();
        if (measurement_valid) begin
            n_pulse++;
            last_psum = int'(period_sum);
            last_per = int'(period);
            last_pulse_cyc = cyc;
        end
        if (timeout) n_to++;
    endtask

    task automatic restart();
        cycle(0, 0, 0);
        cycle(1, 0, 0);
    endtask

    function automatic int sq(input int k, input int p);
        return (k % p) < (p + 1) / 2 ? 1000 : -1000;
    endfunction

    int np0, nt0, st, ph, rp, amp, quiet, s;
    bit en, v;

    initial begin
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        chk("reset period_sum", int'(period_sum), 0);
        chk("reset peak", int'(peak), 0);
        chk("reset mv", int'(measurement_valid), 0);
        chk("reset locked", int'(locked), 0);
        reset = 1'b0;

        // square 5/5 at +-1000
        cycle(1, 0, 0);
        for (int k = 0; k <= 50; k++) cycle(1, 1, sq(k, 10));
        chk("sq mv", int'(measurement_valid), 1);
        chk("sq period_sum", int'(period_sum), 40);
        chk("sq period", int'(period), 10);
        chk("sq peak", int'($signed(peak)), 1000);
        chk("sq trough", int'($signed(trough)), -1000);
        chk("sq amplitude", int'(amplitude), 1000);
        chk("sq locked", int'(locked), 1);
        chk("sq pulses", n_pulse, 1);
        for (int k = 51; k <= 90; k++) cycle(1, 1, sq(k, 10));
        chk("sq second mv", int'(measurement_valid), 1);
        chk("sq pulses2", n_pulse, 2);

        // alternating 10 / 11 sample periods
        restart();
        np0 = n_pulse;
        for (int j = 0; j < 12; j++)
            for (int k = 0; k < ((j % 2) ? 11 : 10); k++)
                cycle(1, 1, sq(k, (j % 2) ? 11 : 10));
        chk("alt pulses", n_pulse - np0, 2);
        chk("alt period_sum", last_psum, 42);
        chk("alt period", last_per, 10);

        // never arms
        restart();
        np0 = n_pulse;
        for (int k = 0; k < 200; k++)
            cycle(1, 1, int'($urandom_range(0, 200)) - 100);
        chk("quiet pulses", n_pulse - np0, 0);
        chk("quiet locked", int'(locked), 0);

        // lock then hold zero until timeout
        restart();
        nt0 = n_to;
        for (int k = 0; k < 60; k++) cycle(1, 1, sq(k, 10));
        chk("to locked before", int'(locked), 1);
        for (int k = 0; k < 100; k++) cycle(1, 1, 0);
        chk("to pulses", n_to - nt0, 1);
        chk("to locked after", int'(locked), 0);
        chk("to period_sum held", int'(period_sum), 40);

        // asynchronous reset mid-window
        restart();
        for (int k = 0; k < 25; k++) cycle(1, 1, sq(k, 10));
        #2 reset = 1'b1;
        #1;
        chk("areset period_sum", int'(period_sum), 0);
        chk("areset amplitude", int'(amplitude), 0);
        chk("areset trough", int'(trough), 0);
        chk("areset locked", int'(locked), 0);
        model_reset();
        #2 reset = 1'b0;

        // 50% sample_valid duty
        np0 = n_pulse;
        cycle(1, 0, 0);
        st = cyc;
        for (int k = 0; k <= 50; k++) begin
            cycle(1, 1, sq(k, 10));
            cycle(1, 0, sq(k, 10));
        end
        chk("duty pulses", n_pulse - np0, 1);
        chk("duty period", last_per, 10);
        chk("duty pulse cycle", last_pulse_cyc - st, 101);

        // sampled sine, 14-sample period
        restart();
        np0 = n_pulse;
        for (int k = 0; k <= 70; k++)
            cycle(1, 1, $rtoi(30000.0 * $sin(6.283185307179586 * k / 14.0)));
        chk("sine pulses", n_pulse - np0, 1);
        chk("sine period_sum", last_psum, 56);
        chk("sine period", last_per, 14);

        // randomized traffic
        ph = 0; rp = 10; amp = 1000; quiet = 0;
        for (int n = 0; n < 4000; n++) begin
            en = $urandom_range(0, 79) != 0;
            v = $urandom_range(0, 3) != 0;
            ph++;
            if (ph >= rp) begin
                ph = 0;
                if ($urandom_range(0, 7) == 0) begin
                    rp = int'($urandom_range(6, 20));
                    amp = int'($urandom_range(0, 2000));
                end
            end
            if (quiet == 0 && $urandom_range(0, 499) == 0) quiet = 150;
            if (quiet > 0) begin
                quiet--;
                s = int'($urandom_range(0, 40)) - 20;
            end else begin
                s = (ph < rp / 2) ? amp : -amp;
                s = s + int'($urandom_range(0, 60)) - 30;
            end
            cycle(en, v, s);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
